// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch types: fetch FSM states, queued entry layout, opcode constants.
// Imported by the fetch queue and the fetch unit top.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch bus: instruction-memory request/response plus the
// valid/ready decode-side queue head.
interface instr_fetch_unit_if;

  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        pred_taken_o;

  modport master (
    output imem_addr_o,
    input  imem_instr_i,
    output valid_o,
    input  ready_i,
    output instr_o,
    output pc_o,
    output pred_taken_o
  );

  modport slave (
    input  imem_addr_o,
    output imem_instr_i,
    input  valid_o,
    output ready_i,
    input  instr_o,
    input  pc_o,
    input  pred_taken_o
  );

endinterface

// File: rtl/instr_fetch_unit_queue.sv
// Synchronous fetch-entry FIFO with push/pop and synchronous clear.
// Pointers carry an extra wrap bit to tell full from empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  fetch_entry_t           wdata_i,
  output fetch_entry_t           rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  fetch_entry_t mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; empty_o masks stale slots.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives imem, queues {pc, instr, pred} for decode.
// Define FETCH_STATIC_PREDICT_EN to follow JAL and backward branches.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic [31:0]         redirect_pc_i,
  instr_fetch_unit_if.master  bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  next_pc;
  logic         next_pred;
  logic         flush_act;
  logic         push;
  logic         pop;
  logic         q_full;
  logic         q_empty;
  fetch_entry_t q_head;
  fetch_entry_t q_wdata;
  logic [$clog2(FIFO_DEPTH):0] q_count;
  logic         unused_bits;

  assign unused_bits = ^{redirect_pc_i[1:0], q_count};

  assign flush_act = flush_i && (state_q != BOOT);
  assign pop  = !q_empty && bus.ready_i && !flush_act;
  assign push = (state_q == RUN) && !stall_i && !flush_act &&
                (!q_full || pop);

`ifdef FETCH_STATIC_PREDICT_EN
  logic [31:0] instr;
  logic [31:0] j_imm;
  logic [31:0] b_imm;
  logic        is_jal;
  logic        is_bwd_br;

  assign instr = bus.imem_instr_i;
  assign j_imm = {{11{instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};
  assign b_imm = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign is_jal    = (instr[6:0] == OPC_JAL);
  assign is_bwd_br = (instr[6:0] == OPC_BRANCH) && instr[31];

  always_comb begin
    next_pc   = fetch_pc_q + 32'd4;
    next_pred = 1'b0;
    unique case (1'b1)
      is_jal: begin
        next_pc   = fetch_pc_q + j_imm;
        next_pred = 1'b1;
      end
      is_bwd_br: begin
        next_pc   = fetch_pc_q + b_imm;
        next_pred = 1'b1;
      end
      default: ;
    endcase
  end
`else
  assign next_pc   = fetch_pc_q + 32'd4;
  assign next_pred = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN:  if (flush_i) state_d = RUN;
            else if (stall_i) state_d = HOLD;
      HOLD: if (flush_i || !stall_i) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // A redirect wins over any push in the same cycle.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (flush_act) fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
    else if (push) fetch_pc_d = next_pc;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign q_wdata = '{pc: fetch_pc_q, instr: bus.imem_instr_i,
                     pred: next_pred};

  fetch_queue #(
    .DEPTH (FIFO_DEPTH)
  ) u_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_i),
    .clear_i (flush_act),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (q_wdata),
    .rdata_o (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  assign bus.imem_addr_o  = fetch_pc_q;
  assign bus.valid_o      = !q_empty;
  assign bus.instr_o      = q_empty ? NOP_INSTR : q_head.instr;
  assign bus.pc_o         = q_empty ? 32'h0 : q_head.pc;
  assign bus.pred_taken_o = !q_empty && q_head.pred;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected entries are queued
// as stimulus is applied and checked as decode accepts them.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] mem [64];

  int vectors = 0;
  int miscompares = 0;
  fetch_entry_t sb[$];

  instr_fetch_unit_if bus();

  always #5 clk = ~clk;

  assign bus.imem_instr_i = (bus.imem_addr_o[31:8] == 24'd0) ?
                            mem[bus.imem_addr_o[7:2]] : 32'h0000_0013;

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_pc_i (redirect_pc_i),
    .bus           (bus)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a[31:8] == 24'd0) return mem[a[7:2]];
    return 32'h0000_0013;
  endfunction

  function automatic void exp_seq(input logic [31:0] pc, input int n);
    logic [31:0] p;
    p = pc;
    for (int i = 0; i < n; i++) begin
      sb.push_back('{pc: p, instr: mem_rd(p), pred: 1'b0});
      p = p + 32'd4;
    end
  endfunction

  task automatic step();
    fetch_entry_t act, exp;
    if (bus.valid_o && bus.ready_i && !flush_i) begin
      act = '{pc: bus.pc_o, instr: bus.instr_o, pred: bus.pred_taken_o};
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL pop_unexpected got pc=%h instr=%h", act.pc, act.instr);
      end else begin
        exp = sb.pop_front();
        if (act !== exp) begin
          miscompares++;
          $display("FAIL pop_entry got pc=%h instr=%h pred=%b want pc=%h instr=%h pred=%b",
                   act.pc, act.instr, act.pred, exp.pc, exp.instr, exp.pred);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    bus.ready_i = 1'b1;
    while (sb.size() != 0 && n < bound) begin
      step();
      n++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout got left=%0d want left=0", sb.size());
      sb.delete();
    end
    bus.ready_i = 1'b0;
  endtask

  task automatic check32(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst_i = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    bus.ready_i = 1'b0;
    step();
    step();
    sb.delete();
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    redirect_pc_i = 32'h0;
    bus.ready_i = 1'b0;
    step();
    step();
    if (bus.imem_addr_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_addr got %h want 0", bus.imem_addr_o);
    end
    vectors++;
    if (bus.valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid got %b want 0", bus.valid_o);
    end
    vectors++;
    if (bus.instr_o !== 32'h0000_0013) begin
      miscompares++;
      $display("FAIL reset_instr got %h want 00000013", bus.instr_o);
    end
    vectors++;
    if (bus.pc_o !== 32'h0 || bus.pred_taken_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pc_pred got %h/%b want 0/0", bus.pc_o, bus.pred_taken_o);
    end
    vectors++;
    rst_i = 1'b1;
  endtask

  task automatic test_sequential();
    exp_seq(32'h0, 3);
    bus.ready_i = 1'b1;
    step();
    check32("seq_addr0", bus.imem_addr_o, 32'h0);
    check32("seq_valid_first", {31'd0, bus.valid_o}, 32'd0);
    step();
    check32("seq_addr4", bus.imem_addr_o, 32'h4);
    check32("seq_valid_second", {31'd0, bus.valid_o}, 32'd1);
    step();
    check32("seq_addr8", bus.imem_addr_o, 32'h8);
    drain(10);
  endtask

  task automatic test_backpressure_stall();
    int pops;
    apply_reset();
    exp_seq(32'h0, 5);
    for (int i = 0; i < 5; i++) step();
    check32("bp_addr_frozen", bus.imem_addr_o, 32'h8);
    check32("bp_head_pc", bus.pc_o, 32'h0);
    stall_i = 1'b1;
    bus.ready_i = 1'b1;
    pops = 0;
    for (int i = 0; i < 6 && bus.valid_o; i++) begin
      pops++;
      step();
    end
    check32("bp_queued_count", pops, 32'd2);
    check32("stall_valid_fell", {31'd0, bus.valid_o}, 32'd0);
    step();
    check32("stall_addr_held", bus.imem_addr_o, 32'h8);
    stall_i = 1'b0;
    drain(20);
  endtask

  task automatic test_flush();
    bus.ready_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check32("flush_pre_valid", {31'd0, bus.valid_o}, 32'd1);
    sb.delete();
    flush_i = 1'b1;
    redirect_pc_i = 32'h0000_000E;
    bus.ready_i = 1'b1;
    step();
    flush_i = 1'b0;
    check32("flush_valid", {31'd0, bus.valid_o}, 32'd0);
    check32("flush_addr", bus.imem_addr_o, 32'hC);
    exp_seq(32'hC, 3);
    drain(10);
  endtask

  task automatic test_wrap();
    flush_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    step();
    flush_i = 1'b0;
    check32("wrap_addr_top", bus.imem_addr_o, 32'hFFFF_FFFC);
    exp_seq(32'hFFFF_FFFC, 1);
    exp_seq(32'h0, 2);
    step();
    check32("wrap_addr_zero", bus.imem_addr_o, 32'h0);
    drain(10);
  endtask

  task automatic test_flush_boot();
    apply_reset();
    flush_i = 1'b1;
    redirect_pc_i = 32'h40;
    step();
    flush_i = 1'b0;
    check32("boot_flush_addr", bus.imem_addr_o, 32'h0);
    exp_seq(32'h0, 2);
    drain(10);
  endtask

  task automatic test_reset_mid();
    bus.ready_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check32("mid_pre_valid", {31'd0, bus.valid_o}, 32'd1);
    rst_i = 1'b0;
    step();
    check32("mid_valid", {31'd0, bus.valid_o}, 32'd0);
    check32("mid_addr", bus.imem_addr_o, 32'h0);
    check32("mid_instr", bus.instr_o, 32'h0000_0013);
    rst_i = 1'b1;
    sb.delete();
  endtask

  task automatic test_predict();
    logic [31:0] tgt;
    logic        pr;
`ifdef FETCH_STATIC_PREDICT_EN
    tgt = 32'h6C;
    pr  = 1'b1;
`else
    tgt = 32'hA4;
    pr  = 1'b0;
`endif
    step();
    flush_i = 1'b1;
    redirect_pc_i = 32'hA0;
    step();
    flush_i = 1'b0;
    check32("pred_addr_a0", bus.imem_addr_o, 32'hA0);
    sb.push_back('{pc: 32'hA0, instr: 32'hfc0006e3, pred: pr});
    exp_seq(tgt, 1);
    step();
    check32("pred_next_addr", bus.imem_addr_o, tgt);
    drain(10);
    flush_i = 1'b1;
    redirect_pc_i = 32'hA4;
    step();
    flush_i = 1'b0;
    sb.push_back('{pc: 32'hA4, instr: 32'h00108663, pred: 1'b0});
    step();
    check32("fwd_br_addr", bus.imem_addr_o, 32'hA8);
    drain(10);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = (32'(i) << 20) | 32'h13;
    mem[0]  = 32'h00a00093;
    mem[1]  = 32'h00102023;
    mem[2]  = 32'h00002103;
    mem[40] = 32'hfc0006e3;
    mem[41] = 32'h00108663;
    bus.ready_i = 1'b0;
    #2;
    test_reset();
    test_sequential();
    test_backpressure_stall();
    test_flush();
    test_wrap();
    test_flush_boot();
    test_reset_mid();
    test_predict();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
